// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, status bit positions, writeback state and
// the opcode-class bundle produced by the writeback decoder.
package cpu_pkg;

    localparam logic [5:0] OpAdd = 6'b010001;
    localparam logic [5:0] OpGha = 6'b010101;
    localparam logic [5:0] OpGhs = 6'b010110;
    localparam logic [5:0] OpMul = 6'b100001;
    localparam logic [5:0] OpRtn = 6'b100110;
    localparam logic [5:0] OpStp = 6'b100111;
    localparam logic [5:0] OpSez = 6'b101001;
    localparam logic [5:0] OpSec = 6'b101101;
    localparam logic [5:0] OpCli = 6'b110110;

    localparam int unsigned StatusZ = 0;
    localparam int unsigned StatusN = 1;
    localparam int unsigned StatusC = 2;
    localparam int unsigned StatusT = 3;
    localparam int unsigned StatusV = 4;
    localparam int unsigned StatusS = 5;
    localparam int unsigned StatusI = 6;

    typedef enum logic [1:0] {
        StRun,
        StMulHi,
        StHalt
    } wb_state_e;

    typedef struct packed {
        logic wr1;
        logic mul;
        logic flag;
        logic stk;
        logic halt;
    } op_class_t;

endpackage

// File: rtl/wb_opcode_class.sv
// Combinational opcode classifier; one opcode may belong to several classes.
module wb_opcode_class
    import cpu_pkg::*;
(
    input  logic [5:0] encoded_opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class      = '0;
        op_class.wr1  = encoded_opcode inside {[6'd6:6'd9], 6'd13, 6'd14, [6'd17:6'd20],
                                               [6'd29:6'd31]};
        op_class.mul  = (encoded_opcode == OpMul);
        // GHA/GHS sit in the flag range but are deliberately absent from wr1.
        op_class.flag = encoded_opcode inside {[6'd6:6'd9], [6'd17:OpGhs], [6'd29:6'd31],
                                               [OpSez:OpCli]};
        op_class.stk  = (encoded_opcode == OpRtn);
        op_class.halt = (encoded_opcode == OpStp);
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU result-commit stage: register-file write strobes, status and stack registers,
// two-cycle MUL writeback and terminal halt.
module alu_writeback
    import cpu_pkg::*;
#(
    parameter logic [7:0]  STATUS_RESET = 8'h00,
    parameter logic [11:0] STACK_RESET  = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [5:0]  encoded_opcode,
    input  logic [2:0]  reg_write_addr,
    input  logic [15:0] aluout1,
    input  logic [15:0] aluout2,
    input  logic [7:0]  statusregout,
    input  logic [11:0] decremented_stack_reg,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [7:0]  status_reg,
    output logic [11:0] stack_reg,
    output logic        halted
);

    wb_state_e   state_q;
    op_class_t   cls;
    logic [2:0]  hi_addr_q;
    logic [15:0] hi_data_q;
    logic        xfer;

    wb_opcode_class u_class (
        .encoded_opcode (encoded_opcode),
        .op_class       (cls)
    );

    // Handshake depends on state only, so there is no path from valid_in to ready_out.
    assign ready_out = (state_q == StRun);
    assign halted    = (state_q == StHalt);
    assign xfer      = valid_in && ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            status_reg <= STATUS_RESET;
            stack_reg  <= STACK_RESET;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
        end else begin
            rf_we <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (xfer) begin
                        if (cls.flag) status_reg <= statusregout;
                        if (cls.stk)  stack_reg  <= decremented_stack_reg;
                        if (cls.wr1 || cls.mul) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= reg_write_addr;
                            rf_wdata <= aluout1;
                        end
                        if (cls.mul) begin
                            hi_addr_q <= reg_write_addr + 3'd1;
                            hi_data_q <= aluout2;
                            state_q   <= StMulHi;
                        end
                        if (cls.halt) state_q <= StHalt;
                    end
                end
                StMulHi: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= hi_addr_q;
                    rf_wdata <= hi_data_q;
                    state_q  <= StRun;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios then random traffic, compared every cycle
// against a queue-based model of scheduled register-file writes.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [5:0]  encoded_opcode;
    logic [2:0]  reg_write_addr;
    logic [15:0] aluout1;
    logic [15:0] aluout2;
    logic [7:0]  statusregout;
    logic [11:0] decremented_stack_reg;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  status_reg;
    logic [11:0] stack_reg;
    logic        halted;

    alu_writeback dut (
        .clk                   (clk),
        .reset                 (reset),
        .valid_in              (valid_in),
        .ready_out             (ready_out),
        .encoded_opcode        (encoded_opcode),
        .reg_write_addr        (reg_write_addr),
        .aluout1               (aluout1),
        .aluout2               (aluout2),
        .statusregout          (statusregout),
        .decremented_stack_reg (decremented_stack_reg),
        .rf_we                 (rf_we),
        .rf_waddr              (rf_waddr),
        .rf_wdata              (rf_wdata),
        .status_reg            (status_reg),
        .stack_reg             (stack_reg),
        .halted                (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: pending writes are a queue of {addr, data}; one leaves per cycle.
    logic [18:0] m_q[$];
    logic        m_halted;
    logic [7:0]  m_status;
    logic [11:0] m_stack;
    int          halt_cycles;

    function automatic bit in_rng(input int op, input int lo, input int hi);
        return op >= lo && op <= hi;
    endfunction

    function automatic bit is_wr1(input int op);
        return in_rng(op, 6, 9) || op == 13 || op == 14 || in_rng(op, 17, 20) ||
               in_rng(op, 29, 31);
    endfunction

    function automatic bit is_flag(input int op);
        return in_rng(op, 6, 9) || in_rng(op, 17, 22) || in_rng(op, 29, 31) ||
               in_rng(op, 41, 54);
    endfunction

    task automatic step(input bit rst, input bit v, input logic [5:0] op, input logic [2:0] rd,
                        input logic [15:0] a1, input logic [15:0] a2, input logic [7:0] sro,
                        input logic [11:0] dsr);
        bit          exp_we;
        bit          after_rst;
        logic [18:0] w;
        bit          m_ready;
        @(negedge clk);
        reset = rst; valid_in = v; encoded_opcode = op; reg_write_addr = rd;
        aluout1 = a1; aluout2 = a2; statusregout = sro; decremented_stack_reg = dsr;
        @(posedge clk);
        m_ready   = (m_q.size() == 0) && !m_halted;
        exp_we    = 1'b0;
        after_rst = rst;
        w         = '0;
        if (rst) begin
            m_q.delete();
            m_halted = 1'b0;
            m_status = 8'h00;
            m_stack  = 12'hFFF;
        end else begin
            if (v && m_ready) begin
                if (is_flag(int'(op))) m_status = sro;
                if (op == 6'd38) m_stack = dsr;
                if (is_wr1(int'(op)) || op == 6'd33) m_q.push_back({rd, a1});
                if (op == 6'd33) m_q.push_back({3'(rd + 3'd1), a2});
                if (op == 6'd39) m_halted = 1'b1;
            end
            if (m_q.size() != 0) begin
                w      = m_q.pop_front();
                exp_we = 1'b1;
            end
        end
        #1;
        check_eq("ready_out", 32'(ready_out), 32'((m_q.size() == 0) && !m_halted));
        check_eq("rf_we", 32'(rf_we), 32'(exp_we));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("status_reg", 32'(status_reg), 32'(m_status));
        check_eq("stack_reg", 32'(stack_reg), 32'(m_stack));
        if (exp_we || after_rst) begin
            check_eq("rf_waddr", 32'(rf_waddr), 32'(w[18:16]));
            check_eq("rf_wdata", 32'(rf_wdata), 32'(w[15:0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
    endtask

    initial begin
        m_halted = 1'b0; m_status = 8'h00; m_stack = 12'hFFF; halt_cycles = 0;
        step(1, 0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
        step(1, 1, 6'd17, 3'd5, 16'hFFFF, 16'h0, 8'hFF, 12'h0);
        // ADD r3
        step(0, 1, 6'd17, 3'd3, 16'h1234, 16'h0, 8'h02, 12'h0);
        idle(1);
        // MUL r7 with the next ADD held valid through the stall
        step(0, 1, 6'd33, 3'd7, 16'hBEEF, 16'h00CA, 8'h55, 12'h0);
        check_eq("mul_lo_addr", 32'(rf_waddr), 32'd7);
        step(0, 1, 6'd17, 3'd1, 16'h1111, 16'h0, 8'h01, 12'h0);
        check_eq("mul_hi_addr", 32'(rf_waddr), 32'd0);
        check_eq("mul_hi_data", 32'(rf_wdata), 32'h00CA);
        step(0, 1, 6'd17, 3'd1, 16'h1111, 16'h0, 8'h01, 12'h0);
        // GHS: flags only
        step(0, 1, 6'd22, 3'd4, 16'hAAAA, 16'h0, 8'h82, 12'h0);
        idle(1);
        // SEC then RTN
        step(0, 1, 6'd45, 3'd2, 16'h5555, 16'h0, 8'h04, 12'h0);
        step(0, 1, 6'd38, 3'd2, 16'h5555, 16'h0, 8'h99, 12'hFFE);
        idle(1);
        // STP then a held ADD, then reset
        step(0, 1, 6'd39, 3'd0, 16'h0, 16'h0, 8'h00, 12'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 6'd17, 3'd6, 16'h7777, 16'h0, 8'h11, 12'h0);
        step(1, 1, 6'd17, 3'd6, 16'h7777, 16'h0, 8'h11, 12'h0);
        idle(1);
        // reset landing on the MUL high-word cycle
        step(0, 1, 6'd33, 3'd2, 16'h1357, 16'h2468, 8'h00, 12'h0);
        step(1, 0, 6'd0, 3'd0, 16'h0, 16'h0, 8'h0, 12'h0);
        idle(2);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit rst;
            rst = ($urandom_range(0, 99) < 2) || (halt_cycles > 4);
            step(rst, $urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)),
                 3'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 12'($urandom));
            halt_cycles = m_halted ? halt_cycles + 1 : 0;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
